// File: rtl/axis_mux_sel_rr_pick.sv
// Combinational grant picker for the AXI-Stream mux controller.
// Round-robin searches upward from last_grant+1 with wrap; fixed mode takes the lowest set bit.
module axis_mux_sel_rr_pick #(
    parameter int S_COUNT = 4,
    localparam int SW = $clog2(S_COUNT)
) (
    input  logic [S_COUNT-1:0] req,
    input  logic [SW-1:0]      last_grant,
    input  logic               round_robin,
    output logic [SW-1:0]      idx,
    output logic               vld
);

    always_comb begin
        int cand;
        cand = 0;
        idx  = '0;
        vld  = 1'b0;
        for (int k = 0; k < S_COUNT; k++) begin
            cand = round_robin ? (int'(last_grant) + 1 + k) % S_COUNT : k;
            if (!vld && req[SW'(cand)]) begin
                idx = SW'(cand);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_mux_sel_ctrl.sv
// Frame-aware arbiter driving enable/sel of an AXI-Stream mux; sel only moves between frames.
// A granted input that never starts a frame is dropped after TIMEOUT cycles.
module axis_mux_sel_ctrl #(
    parameter int S_COUNT     = 4,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 16,
    parameter int CNT_WIDTH   = $clog2(TIMEOUT + 1),
    localparam int SW = $clog2(S_COUNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_COUNT-1:0] s_axis_tvalid,
    input  logic [S_COUNT-1:0] s_axis_tready,
    input  logic [S_COUNT-1:0] s_axis_tlast,
    input  logic [S_COUNT-1:0] port_mask,
    output logic               enable,
    output logic [SW-1:0]      sel,
    output logic               busy
);

    localparam int CW = (CNT_WIDTH < 1) ? 1 : CNT_WIDTH;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] last_grant_q, last_grant_d;
    logic [SW-1:0] sel_q, sel_d;
    logic          enable_q, enable_d;
    logic          busy_q, busy_d;

    logic [SW-1:0] pick_idx;
    logic          pick_vld;
    logic          hs, hs_last, timeout_hit;

    axis_mux_sel_rr_pick #(.S_COUNT(S_COUNT)) u_pick (
        .req         (s_axis_tvalid & port_mask),
        .last_grant  (last_grant_q),
        .round_robin (ROUND_ROBIN != 0),
        .idx         (pick_idx),
        .vld         (pick_vld)
    );

    assign hs          = s_axis_tvalid[sel_q] & s_axis_tready[sel_q];
    assign hs_last     = hs & s_axis_tlast[sel_q];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= SW'(S_COUNT - 1);
            sel_q        <= '0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d      = ST_GRANT;
                    sel_d        = pick_idx;
                    last_grant_d = pick_idx;
                    cnt_d        = '0;
                end
            end
            ST_GRANT: begin
                // a handshake in the expiry cycle takes precedence over the timeout
                if (hs_last)          state_d = ST_IDLE;
                else if (hs)          state_d = ST_XFER;
                else if (timeout_hit) state_d = ST_IDLE;
                else if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
            end
            ST_XFER: begin
                if (hs_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs are registered from the next state so enable falls on the tlast edge
    always_comb begin
        enable_d = (state_d != ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    assign enable = enable_q;
    assign sel    = sel_q;
    assign busy   = busy_q;

endmodule

// File: doc/axis_mux_sel_ctrl.md
Name: axis_mux_sel_ctrl

Overview:
- Frame-aware arbiter that drives the `enable`/`sel` control inputs of an AXI4-Stream port mux (axis_mux_wrap).
- Sits beside the mux, directly upstream of its control port. It monitors the mux's slave-side handshakes so that `sel` only changes between frames.
- Grants inputs round-robin or fixed-priority.
- Skips an input that is granted but never starts a frame, after a timeout.

Parameters:
- S_COUNT, 4, number of mux inputs; must be >= 2.
- ROUND_ROBIN, 1, 1 = round-robin from last grant; 0 = fixed priority, lowest index wins.
- TIMEOUT, 16, cycles in GRANT without a frame start before the grant is released; 0 disables the timeout.
- CNT_WIDTH, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- s_axis_tvalid  in  S_COUNT  tvalid of each mux input (monitor only).
- s_axis_tready  in  S_COUNT  tready returned by the mux to each input (monitor only).
- s_axis_tlast  in  S_COUNT  tlast of each mux input (monitor only).
- port_mask  in  S_COUNT  1 = input eligible for grant.
- enable  out  1  to mux enable; registered.
- sel  out  $clog2(S_COUNT)  to mux sel; registered.
- busy  out  1  high in GRANT or XFER; registered.

Behaviour:
- Reset values: enable=0, sel=0, busy=0, state=IDLE, timeout counter=0, last_grant=S_COUNT-1 (so the first round-robin pick is index 0).
- Let req = s_axis_tvalid & port_mask.
- Let hs = s_axis_tvalid[sel] & s_axis_tready[sel].
- Let hs_last = hs & s_axis_tlast[sel].

- IDLE (enable=0):
  - If req != 0: pick an index. ROUND_ROBIN=1 picks the first set bit of req searching upward from last_grant+1 with wrap-around. ROUND_ROBIN=0 picks the lowest set bit.
  - On the same edge: sel<=idx, enable<=1, busy<=1, last_grant<=idx, counter<=0, go to GRANT.
  - If req == 0: stay in IDLE, sel holds its value.
- GRANT (enable=1, waiting for first beat):
  - hs_last (single-beat frame): enable<=0, busy<=0, go to IDLE.
  - hs without tlast: go to XFER.
  - Neither, TIMEOUT != 0, and counter == TIMEOUT-1: enable<=0, busy<=0, go to IDLE. Else counter increments, saturating.
  - Handshake and timeout expiry in the same cycle: the handshake wins.
- XFER (enable=1):
  - On hs_last: enable<=0, busy<=0, go to IDLE.
  - Otherwise hold. No timeout applies in XFER; a stalled frame holds the grant indefinitely.
- Enable drop timing: enable is deasserted on the edge that registers the input-side tlast handshake. The mux therefore sees enable=0 before it can latch a new frame on the old sel.
- sel is never changed while enable=1.
- Latency:
  - Request to enable/sel valid: 1 cycle.
  - Minimum gap between back-to-back frames: 1 IDLE cycle, plus the cycle to re-grant.
- Masking and the current grant:
  - port_mask changes affect only the next arbitration; they never abort a granted frame.
  - Deassertion of s_axis_tvalid[sel] mid-frame (a bubble) does not release the grant.
- Reset mid-frame returns to the reset values immediately. The mux is reset by the same rst, so no partial-frame handling is required.
- If a sel index >= S_COUNT would result (non-power-of-2 S_COUNT), it can never be chosen because req has no such bit.

Decomposition:
- No shared package needed. The local state encoding (IDLE/GRANT/XFER) uses localparams in the module.
- One natural sub-module: axis_mux_sel_rr_pick.
  - Combinational priority picker.
  - Inputs: req, last_grant, round_robin mode.
  - Outputs: idx and a valid flag.
  - Lets the picker be unit-tested in isolation.

Test Plan:
- Round-robin fairness. S_COUNT=4, ROUND_ROBIN=1, all tvalid=1 continuously, 3-beat frames, tready=1 → sel sequence 0,1,2,3,0.
  - enable low for exactly 1 cycle after each tlast handshake.
  - sel constant while enable=1.
- Fixed priority. ROUND_ROBIN=0, inputs 1 and 3 always valid → sel stays 1 for every frame; input 3 is never granted.
- Timeout. TIMEOUT=4, input 2 requests then drops tvalid on the grant cycle → after 4 GRANT cycles enable=0, busy=0; next request on input 0 is granted, sel=0.
- Single-beat frame plus simultaneous timeout. TIMEOUT=4, hs_last arrives on the 4th GRANT cycle → frame accepted, no timeout; IDLE next cycle.
- Mask and backpressure. port_mask=4'b1011 with all valid → input 2 never selected. tready toggled 1/0 mid-frame → grant held until tlast handshake.
- Reset mid-frame. rst asserted during XFER on input 1 → next cycle enable=0, sel=0, busy=0; after release, first grant goes to input 0.
